pattern_scan_ctrl: RTL and testbench

//   Run-time programmable serial pattern scanner and match scheduler. Accepts parallel words

---
 rtl/pattern_scan_pkg.sv | 15 +
 rtl/pattern_scan_ctrl_if.sv | 9 +
 rtl/pattern_match_core.sv | 60 ++++++
 rtl/pattern_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_scan_pkg.sv
// Shared types and helpers for the pattern scanner.
// Build option: PATTERN_MASK_EN adds a per-position don't-care mask.
package pattern_scan_pkg;
  localparam int WORD_W_DF    = 8;
  localparam int PAT_W_MAX_DF = 8;
  localparam int CNT_W_DF     = 16;
  localparam int LEN_W        = $clog2(PAT_W_MAX_DF) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT} state_e;

  // Increment that holds at lim; callers narrow the result to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction
endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Word stream into the scanner: valid/ready handshake plus data.
interface pattern_scan_ctrl_if #(parameter int WORD_W = 8);
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/pattern_match_core.sv
// Bit history, fill count and (optionally masked) compare with a registered match pulse.
// Build option: PATTERN_MASK_EN adds the mask input.
module pattern_match_core
  import pattern_scan_pkg::*;
#(
  parameter int PAT_W_MAX = PAT_W_MAX_DF,
  parameter int LW        = $clog2(PAT_W_MAX) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 shift_en,
  input  logic                 bit_in,
  input  logic [PAT_W_MAX-1:0] pat,
`ifdef PATTERN_MASK_EN
  input  logic [PAT_W_MAX-1:0] mask,
`endif
  input  logic [LW-1:0]        len,
  output logic                 match
);
  logic [PAT_W_MAX-1:0] hist_q, hist_d;
  logic [PAT_W_MAX-1:0] len_mask, care;
  logic [LW-1:0]        seen_q, seen_d;
  logic                 match_q, match_d;

  always_comb begin
    for (int i = 0; i < PAT_W_MAX; i++) len_mask[i] = (i < int'(len));
`ifdef PATTERN_MASK_EN
    care = len_mask & mask;
`else
    care = len_mask;
`endif
    hist_d  = hist_q;
    seen_d  = seen_q;
    match_d = 1'b0;
    if (clr) begin
      hist_d = '0;
      seen_d = '0;
    end else if (shift_en) begin
      // Newest bit lands in position 0; the oldest compared bit sits at len-1.
      hist_d  = PAT_W_MAX'({hist_q, bit_in});
      seen_d  = LW'(sat_inc(32'(seen_q), 32'(PAT_W_MAX)));
      match_d = (((hist_d ^ pat) & care) == '0) && (seen_d >= len);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= '0;
      seen_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      seen_q  <= seen_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;
endmodule

// File: rtl/pattern_scan_ctrl.sv
// Word serialiser, scan FSM, saturating match counter and sticky threshold interrupt.
// Build option: PATTERN_MASK_EN adds cfg_mask (latched at start).
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DF,
  parameter int PAT_W_MAX = PAT_W_MAX_DF,
  parameter int CNT_W     = CNT_W_DF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          stop,
  input  logic [PAT_W_MAX-1:0]          cfg_pattern,
`ifdef PATTERN_MASK_EN
  input  logic [PAT_W_MAX-1:0]          cfg_mask,
`endif
  input  logic [$clog2(PAT_W_MAX):0]    cfg_len,
  input  logic [CNT_W-1:0]              cfg_thresh,
  pattern_scan_ctrl_if.slave            s,
  output logic                          match,
  output logic [CNT_W-1:0]              match_cnt,
  output logic                          busy,
  output logic                          irq,
  input  logic                          irq_clr
);
  localparam int LW = $clog2(PAT_W_MAX) + 1;
  localparam int IW = $clog2(WORD_W);

  state_e               state_q, state_d;
  logic [WORD_W-1:0]    word_q, word_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [PAT_W_MAX-1:0] pat_q, pat_d;
  logic [LW-1:0]        len_q, len_d;
  logic [CNT_W-1:0]     thr_q, thr_d, cnt_q, cnt_d, cnt_inc;
  logic                 irq_q, irq_d;
`ifdef PATTERN_MASK_EN
  logic [PAT_W_MAX-1:0] mask_q, mask_d;
`endif
  logic start_go, accept, shift_en, core_clr, core_match;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; stop dominates start and any handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !stop) state_d = WAIT;
      WAIT:    if (stop) state_d = IDLE; else if (s.s_valid) state_d = SHIFT;
      SHIFT:   if (stop) state_d = IDLE; else if (idx_q == '0) state_d = WAIT;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    s.s_ready = (state_q == WAIT);
    busy      = (state_q != IDLE);
    start_go  = (state_q == IDLE) && start && !stop;
    accept    = (state_q == WAIT) && s.s_valid && !stop;
    shift_en  = (state_q == SHIFT) && !stop;
    core_clr  = start_go || ((state_q != IDLE) && stop);
  end

  always_comb begin
    word_d  = word_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    len_d   = len_q;
    thr_d   = thr_q;
    cnt_d   = cnt_q;
    irq_d   = irq_q;
`ifdef PATTERN_MASK_EN
    mask_d  = mask_q;
`endif
    cnt_inc = CNT_W'(sat_inc(32'(cnt_q), 32'({CNT_W{1'b1}})));
    if (start_go) begin
      pat_d = cfg_pattern;
      thr_d = cfg_thresh;
      if (cfg_len == '0)                 len_d = LW'(1);
      else if (cfg_len > LW'(PAT_W_MAX)) len_d = LW'(PAT_W_MAX);
      else                               len_d = cfg_len;
`ifdef PATTERN_MASK_EN
      mask_d = cfg_mask;
`endif
    end
    if (accept) begin
      word_d = s.s_data;
      idx_d  = IW'(WORD_W - 1);
    end else if (shift_en && idx_q != '0) begin
      idx_d = idx_q - 1'b1;
    end
    if (start_go) begin
      cnt_d = '0;
      irq_d = 1'b0;
    end else begin
      if (core_match) cnt_d = cnt_inc;
      // Set only on the transition into the threshold; set beats a same-cycle clear.
      if (core_match && thr_q != '0 && cnt_inc == thr_q && cnt_inc != cnt_q) irq_d = 1'b1;
      else if (irq_clr) irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
      pat_q  <= '0;
      len_q  <= LW'(1);
      thr_q  <= '0;
      cnt_q  <= '0;
      irq_q  <= 1'b0;
`ifdef PATTERN_MASK_EN
      mask_q <= '1;
`endif
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      thr_q  <= thr_d;
      cnt_q  <= cnt_d;
      irq_q  <= irq_d;
`ifdef PATTERN_MASK_EN
      mask_q <= mask_d;
`endif
    end
  end

  pattern_match_core #(.PAT_W_MAX(PAT_W_MAX), .LW(LW)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (core_clr),
    .shift_en (shift_en),
    .bit_in   (word_q[idx_q]),
    .pat      (pat_q),
`ifdef PATTERN_MASK_EN
    .mask     (mask_q),
`endif
    .len      (len_q),
    .match    (core_match)
  );

  assign match     = core_match;
  assign match_cnt = cnt_q;
  assign irq       = irq_q;
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed plus randomized bench for pattern_scan_ctrl against a bit-list reference model.
module tb_pattern_scan_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, irq_clr = 1'b0;
  logic [7:0]  cfg_pattern = '0;
  logic [3:0]  cfg_len = '0;
  logic [15:0] cfg_thresh = '0;
`ifdef PATTERN_MASK_EN
  logic [7:0]  cfg_mask = '1;
  localparam logic [7:0] MASK_FORCE = 8'h00;
`else
  localparam logic [7:0] MASK_FORCE = 8'hFF;
`endif
  logic        match, busy, irq;
  logic [15:0] match_cnt;

  pattern_scan_ctrl_if #(.WORD_W(8)) sif ();

  pattern_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_pattern(cfg_pattern),
`ifdef PATTERN_MASK_EN
    .cfg_mask(cfg_mask),
`endif
    .cfg_len(cfg_len), .cfg_thresh(cfg_thresh), .s(sif),
    .match(match), .match_cnt(match_cnt), .busy(busy), .irq(irq), .irq_clr(irq_clr)
  );

  always #5 clk = ~clk;

  int ncmp = 0, nfail = 0;
  int mbits[$];
  int mlen = 1;
  logic [7:0]  mpat = '0, mmask = '1;
  logic [15:0] mcnt = '0, mthr = '0;
  logic        mirq = 1'b0, pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Match when the newest mlen bits equal the pattern, pattern bit 0 = newest bit.
  function automatic logic model_match();
    if (mbits.size() < mlen) return 1'b0;
    for (int i = 0; i < mlen; i++)
      if (mmask[i] && (mbits[mbits.size()-1-i] != int'(mpat[i]))) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: count the pulse seen last cycle, then apply this edge's shift or clear.
  task automatic tick(input bit sh, input bit b, input bit clr_h);
    logic [15:0] nc;
    @(posedge clk);
    if (pend) begin
      nc = (mcnt == 16'hFFFF) ? mcnt : mcnt + 16'd1;
      if (mthr != 0 && nc == mthr && nc != mcnt) mirq = 1'b1;
      else if (irq_clr) mirq = 1'b0;
      mcnt = nc;
    end else if (irq_clr) mirq = 1'b0;
    pend = 1'b0;
    if (clr_h) mbits.delete();
    else if (sh) begin
      mbits.push_back(int'(b));
      if (mbits.size() > 8) void'(mbits.pop_front());
      pend = model_match();
    end
    #1;
    chk("match", 32'(match), 32'(pend));
    chk("match_cnt", 32'(match_cnt), 32'(mcnt));
    chk("irq", 32'(irq), 32'(mirq));
  endtask

  task automatic do_start(input logic [7:0] pat, input logic [3:0] len,
                          input logic [15:0] thr, input logic [7:0] msk);
    cfg_pattern = pat; cfg_len = len; cfg_thresh = thr;
`ifdef PATTERN_MASK_EN
    cfg_mask = msk;
`endif
    start = 1'b1;
    @(posedge clk);
    mbits.delete(); mcnt = '0; mirq = 1'b0; pend = 1'b0;
    mpat = pat; mthr = thr; mmask = msk | MASK_FORCE;
    mlen = (len == 0) ? 1 : ((len > 8) ? 8 : int'(len));
    #1;
    start = 1'b0;
    cfg_pattern = 8'($urandom); cfg_len = 4'($urandom); cfg_thresh = 16'($urandom);
`ifdef PATTERN_MASK_EN
    cfg_mask = 8'($urandom);
`endif
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ready", 32'(sif.s_ready), 32'd1);
    chk("start_cnt", 32'(match_cnt), 32'd0);
    chk("start_irq", 32'(irq), 32'd0);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick(1'b0, 1'b0, 1'b1);
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_ready", 32'(sif.s_ready), 32'd0);
  endtask

  // Send one word; shift nbits of it, then either stop or finish the word.
  task automatic send(input logic [7:0] w, input int nbits, input bit do_stp, input int clr_k);
    int waitc = 0;
    sif.s_valid = 1'b1; sif.s_data = w;
    while (!sif.s_ready && waitc < 20) begin tick(1'b0, 1'b0, 1'b0); waitc++; end
    chk("ready_wait", 32'(sif.s_ready), 32'd1);
    if (!sif.s_ready) begin sif.s_valid = 1'b0; return; end
    tick(1'b0, 1'b0, 1'b0);
    sif.s_valid = 1'b0; sif.s_data = 8'($urandom);
    chk("shift_busy", 32'(busy), 32'd1);
    chk("shift_ready", 32'(sif.s_ready), 32'd0);
    for (int k = 0; k < nbits; k++) begin
      tick(1'b1, w[7-k], 1'b0);
      if (irq_clr) irq_clr = 1'b0;
      if (k == clr_k) irq_clr = 1'b1;
    end
    if (do_stp) do_stop();
    else begin
      tick(1'b0, 1'b0, 1'b0);
      irq_clr = 1'b0;
      chk("word_ready", 32'(sif.s_ready), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.s_valid = 1'b0; sif.s_data = '0;
    #2;
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ready", 32'(sif.s_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Overlapping matches inside one word
    do_start(8'h0B, 4'd4, 16'd0, 8'hFF);
    send(8'hB6, 8, 1'b0, -1);
    chk("t1_cnt", 32'(match_cnt), 32'd2);
    // start while busy is ignored
    start = 1'b1; cfg_pattern = 8'h00; cfg_len = 4'd1;
    tick(1'b0, 1'b0, 1'b0);
    start = 1'b0;
    chk("busy_start_cnt", 32'(match_cnt), 32'd2);

    // Match spanning a word boundary
    do_stop();
    do_start(8'h0B, 4'd4, 16'd0, 8'hFF);
    send(8'h01, 8, 1'b0, -1);
    send(8'h60, 8, 1'b0, -1);
    chk("t2_cnt", 32'(match_cnt), 32'd1);

    // Threshold irq, set beats same-cycle clear, then explicit clear
    do_stop();
    do_start(8'h0B, 4'd4, 16'd2, 8'hFF);
    send(8'hB6, 8, 1'b0, 6);
    chk("t3_irq_set", 32'(irq), 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("t3_irq_hold", 32'(irq), 32'd1);
    irq_clr = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    irq_clr = 1'b0;
    chk("t3_irq_clr", 32'(irq), 32'd0);

    // Stop mid-word keeps the count
    do_stop();
    do_start(8'h0B, 4'd4, 16'd0, 8'hFF);
    send(8'hB6, 8, 1'b0, -1);
    send(8'hB6, 3, 1'b1, -1);
    chk("t4_cnt", 32'(match_cnt), 32'd2);
    chk("t4_match", 32'(match), 32'd0);

    // Asynchronous reset mid-shift, then a clean rerun
    do_start(8'h0B, 4'd4, 16'd0, 8'hFF);
    send(8'hB6, 8, 1'b0, -1);
    sif.s_valid = 1'b1; sif.s_data = 8'hB6;
    tick(1'b0, 1'b0, 1'b0);
    sif.s_valid = 1'b0;
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_match", 32'(match), 32'd0);
    chk("t5_cnt", 32'(match_cnt), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_irq", 32'(irq), 32'd0);
    chk("t5_ready", 32'(sif.s_ready), 32'd0);
    mbits.delete(); mcnt = '0; mirq = 1'b0; pend = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    do_start(8'h0B, 4'd4, 16'd0, 8'hFF);
    send(8'hB6, 8, 1'b0, -1);
    chk("t5_rerun_cnt", 32'(match_cnt), 32'd2);

    // Length 0 acts as 1: every '1' bit matches
    do_stop();
    do_start(8'h01, 4'd0, 16'd0, 8'hFF);
    send(8'hA5, 8, 1'b0, -1);
    chk("len0_cnt", 32'(match_cnt), 32'd4);

    // Oversized length clamps to 8
    do_stop();
    do_start(8'hFF, 4'd13, 16'd0, 8'hFF);
    send(8'hFF, 8, 1'b0, -1);
    chk("len_clamp_cnt", 32'(match_cnt), 32'd1);

`ifdef PATTERN_MASK_EN
    do_stop();
    do_start(8'h0B, 4'd4, 16'd0, 8'h0D);
    send(8'h90, 8, 1'b0, -1);
    chk("t6_mask_cnt", 32'(match_cnt), 32'd1);
`endif

    // Randomized segments against the model
    for (int seg = 0; seg < 10; seg++) begin
      do_stop();
      do_start(8'($urandom), 4'($urandom_range(0, 15)), 16'($urandom_range(0, 4)), 8'($urandom));
      for (int w = 0; w < 6; w++) begin
        if ($urandom_range(0, 3) == 0) tick(1'b0, 1'b0, 1'b0);
        if (w == 5 && $urandom_range(0, 1) == 1)
          send(8'($urandom), $urandom_range(1, 7), 1'b1, -1);
        else
          send(8'($urandom), 8, 1'b0, $urandom_range(0, 12));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
